// File: rtl/rle_block_sequencer_if.sv
// Block-in / row-out handshake bundle for rle_block_sequencer.
// slave is the sequencer's view; master is the upstream/downstream view.
interface rle_block_sequencer_if #(
  parameter int unsigned PAIR_W = 14,
  parameter int unsigned NPAIRS = 64,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned ROWS   = 8
);
  localparam int unsigned RIDX_W = $clog2(ROWS);

  logic                       in_valid;
  logic                       in_ready;
  logic [PAIR_W*NPAIRS-1:0]   in_data;
  logic                       out_valid;
  logic                       out_ready;
  logic [COEF_W*ROWS-1:0]     out_row;
  logic [RIDX_W-1:0]          out_row_idx;
  logic                       out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_row, out_row_idx, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_row, out_row_idx, out_last
  );
endinterface

// File: rtl/rle_block_sequencer.sv
// Steps the external 8-coefficient run-length expander across one 64-pair block,
// emitting its output as 8 row beats and feeding the residual back each beat.
module rle_block_sequencer #(
  parameter int unsigned PAIR_W = 14,
  parameter int unsigned NPAIRS = 64,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned ROWS   = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  rle_block_sequencer_if.slave      bus,
  output logic [PAIR_W*NPAIRS-1:0]  dec_data_in,
  input  logic [COEF_W*ROWS-1:0]    dec_result,
  input  logic [PAIR_W*NPAIRS-1:0]  dec_data_out,
  output logic                      busy,
  output logic [CNT_W-1:0]          block_count
);
  localparam int unsigned RIDX_W = $clog2(ROWS);
  localparam logic [RIDX_W-1:0] LAST_ROW = RIDX_W'(ROWS - 1);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e                   state_q;
  logic [PAIR_W*NPAIRS-1:0] work_q;
  logic [RIDX_W-1:0]        row_q;
  logic                     out_valid_q;
  logic                     out_last_q;
  logic                     busy_q;
  logic [CNT_W-1:0]         cnt_q;

  logic last_hs;
  logic load;

  // A new block may enter either from IDLE or on the final row's handshake,
  // which is what allows back-to-back blocks without a bubble.
  assign last_hs      = (state_q == EMIT) && bus.out_ready && (row_q == LAST_ROW);
  assign bus.in_ready = !rst && ((state_q == IDLE) || last_hs);
  assign load         = bus.in_valid && bus.in_ready;

  assign dec_data_in     = work_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_row     = dec_result;
  assign bus.out_row_idx = row_q;
  assign bus.out_last    = out_last_q;
  assign busy            = busy_q;
  assign block_count     = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      work_q      <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load) begin
            work_q      <= bus.in_data;
            row_q       <= '0;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= EMIT;
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            if (row_q != LAST_ROW) begin
              work_q     <= dec_data_out;
              row_q      <= row_q + 1'b1;
              out_last_q <= (row_q == LAST_ROW - 1'b1);
            end else begin
              cnt_q      <= cnt_q + 1'b1;
              row_q      <= '0;
              out_last_q <= 1'b0;
              if (load) begin
                work_q <= bus.in_data;
              end else begin
                work_q      <= '0;
                out_valid_q <= 1'b0;
                busy_q      <= 1'b0;
                state_q     <= IDLE;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
